fabric_config_loader: RTL and testbench
=======================================

Name: fabric_config_loader

Overview:
- Parametrised bitstream-source manager between N configuration sources (SPI controller, SPI receiver, future JTAG/parallel) and fabric_config.
- Replaces the fixed two-way combinational mux and single-shot startup trigger.
- Adds:
  - mode synchronisation with safe switch points
  - a load state machine
  - re-configuration requests
  - a per-load stall watchdog
  - source enables that drive the pad output enables.

Parameters:
- NUM_SOURCES, 2, number of bitstream sources (>=2); source index = value of mode_i.
- ACTIVE_MASK, 'b01, bit s=1: source s is active (needs start pulse); 0: passive (pushes data unsolicited).
- DATA_W, 32, bitstream word width.
- SLOT_W, 4, slot index width forwarded to active sources.
- SYNC_STAGES, 2, synchroniser depth for mode_i and reconfig_i (>=2).
- TIMEOUT_CYCLES, 2**20, max cycles in LOAD without a valid word before error.
- MODE_W, $clog2(NUM_SOURCES), derived, not overridable.

Ports:
- fpga_clk_i  in  1  clock
- fpga_rst_i  in  1  reset, asynchronous, active-high
- mode_i  in  MODE_W  asynchronous source select
- slot_i  in  SLOT_W  slot for active sources, sampled at START
- reconfig_i  in  1  asynchronous level; rising edge requests reload
- src_enable_o  out  NUM_SOURCES  one-hot; selected source may drive pads
- src_start_o  out  NUM_SOURCES  one-cycle start pulse to active source
- src_slot_o  out  SLOT_W  latched slot
- src_busy_i  in  NUM_SOURCES  source busy flags
- src_data_i  in  NUM_SOURCES*DATA_W  packed words, source s at [s*DATA_W +: DATA_W]
- src_valid_i  in  NUM_SOURCES  word valid per source
- cfg_data_o  out  DATA_W  word to fabric_config
- cfg_valid_o  out  1  valid to fabric_config
- cfg_busy_i  in  1  fabric_config busy
- cfg_configured_i  in  1  fabric_config configured
- active_src_o  out  MODE_W  source latched for current/last load
- busy_o  out  1  state != IDLE/DONE/ERROR
- done_o  out  1  last load completed
- error_o  out  1  last load timed out
- word_count_o  out  32  see Optional Feature

Behaviour:
- Reset values:
  - All outputs 0; src_enable_o = 0, so all pads tri-stated during reset.
  - State IDLE; one pending startup request set.
- Synchronisers: mode_sync and reconfig_sync each pass through SYNC_STAGES flops. Reconfig request = rising edge of reconfig_sync.
- mode_sync >= NUM_SOURCES is out of range: treated as no selection. src_enable_o = 0; no load starts.
- States:
  - IDLE: src_enable_o tracks mode_sync every cycle. If a startup or reconfig request is pending, go to START. The startup request is consumed only when the selected source is active; a passive source goes directly to LOAD.
  - START (1 cycle):
    - latch active_src_o = mode_sync and src_slot_o = slot_i;
    - pulse src_start_o[active] if ACTIVE_MASK[active];
    - clear done_o, error_o, the watchdog and the seen_busy flag;
    - go to LOAD.
  - LOAD:
    - cfg_data_o/cfg_valid_o are registered copies of the active source's word/valid (latency 1 cycle). Other sources' valids are ignored.
    - seen_busy is set when cfg_busy_i = 1.
    - The watchdog increments each cycle without the active valid and resets on a valid.
    - When seen_busy && !cfg_busy_i && cfg_configured_i && !src_busy_i[active], go to DONE.
    - When the watchdog reaches TIMEOUT_CYCLES-1, go to ERROR. This check takes priority over the completion check in the same cycle.
  - DONE: done_o = 1. On mode_sync change, update src_enable_o. On a reconfig request, go to START.
  - ERROR: error_o = 1 (sticky). Same exits as DONE.
- mode changes during START/LOAD are ignored; active_src_o and src_enable_o stay frozen until LOAD exits.
- A reconfig request during START/LOAD is dropped.
- Reconfig and mode change in the same cycle in DONE/ERROR: the new mode is used.
- Passive source: LOAD waits for data, and the watchdog runs from entry to LOAD.
- Reset asserted mid-LOAD: immediate return to reset values; cfg_valid_o drops asynchronously. After reset release, a new startup request is pending.

Optional Feature:
- Macro: FABRIC_CONFIG_WORD_COUNT_EN.
- Defined: word_count_o counts cfg_valid_o words forwarded in the current/last load. It clears at START and saturates at 32'hFFFF_FFFF.
- Undefined: no counter logic; word_count_o tied to 0.

Test Plan:
- Reset release with mode_i=0 (active), slot_i=3 -> after SYNC_STAGES+1 cycles, src_start_o=2'b01 for exactly one cycle and src_slot_o=3. Then 4 valid words -> cfg_valid_o high 4 cycles, each 1 cycle late. Then fabric busy 1->0 with configured=1 -> done_o=1, word_count_o=4 (macro on).
- mode_i=1 (passive) at reset -> src_start_o stays 0 and src_enable_o=2'b10. Data on source 0 is ignored; data on source 1 is forwarded.
- mode_i toggled 0->1 mid-LOAD -> active_src_o and src_enable_o unchanged until DONE, then src_enable_o=2'b10 within SYNC_STAGES+1 cycles.
- TIMEOUT_CYCLES=64, no valid after START -> ERROR after 64 cycles, error_o=1, busy_o=0. A reconfig rising edge then restarts: error_o clears and start pulses again.
- fpga_rst_i asserted during LOAD with cfg_valid_o=1 -> all outputs 0 immediately. After release, the startup load repeats.
- NUM_SOURCES=3 and mode_i=3 -> src_enable_o=0, no start pulse, busy_o=0.

Source files
------------

// File: rtl/fabric_config_loader_if.sv
// Signal bundle between fabric_config_loader, its bitstream sources and fabric_config.
// master = loader side, slave = the sources, fabric_config and control logic around it.
interface fabric_config_loader_if #(
  parameter int NUM_SOURCES = 2,
  parameter int DATA_W      = 32,
  parameter int SLOT_W      = 4
);
  localparam int MODE_W = $clog2(NUM_SOURCES);

  logic [MODE_W-1:0]             mode_i;
  logic [SLOT_W-1:0]             slot_i;
  logic                          reconfig_i;
  logic [NUM_SOURCES-1:0]        src_enable_o;
  logic [NUM_SOURCES-1:0]        src_start_o;
  logic [SLOT_W-1:0]             src_slot_o;
  logic [NUM_SOURCES-1:0]        src_busy_i;
  logic [NUM_SOURCES*DATA_W-1:0] src_data_i;
  logic [NUM_SOURCES-1:0]        src_valid_i;
  logic [DATA_W-1:0]             cfg_data_o;
  logic                          cfg_valid_o;
  logic                          cfg_busy_i;
  logic                          cfg_configured_i;
  logic [MODE_W-1:0]             active_src_o;
  logic                          busy_o;
  logic                          done_o;
  logic                          error_o;
  logic [31:0]                   word_count_o;

  modport master (
    input  mode_i, slot_i, reconfig_i, src_busy_i, src_data_i, src_valid_i,
           cfg_busy_i, cfg_configured_i,
    output src_enable_o, src_start_o, src_slot_o, cfg_data_o, cfg_valid_o,
           active_src_o, busy_o, done_o, error_o, word_count_o
  );

  modport slave (
    output mode_i, slot_i, reconfig_i, src_busy_i, src_data_i, src_valid_i,
           cfg_busy_i, cfg_configured_i,
    input  src_enable_o, src_start_o, src_slot_o, cfg_data_o, cfg_valid_o,
           active_src_o, busy_o, done_o, error_o, word_count_o
  );
endinterface

// File: rtl/fabric_config_loader.sv
// Selects one of N bitstream sources and sequences loads into fabric_config; source word to cfg in 1 cycle,
// no backpressure (words forwarded unconditionally). FABRIC_CONFIG_WORD_COUNT_EN adds the forwarded-word counter.
module fabric_config_loader #(
  parameter int                     NUM_SOURCES    = 2,
  parameter logic [NUM_SOURCES-1:0] ACTIVE_MASK    = NUM_SOURCES'(1),
  parameter int                     DATA_W         = 32,
  parameter int                     SLOT_W         = 4,
  parameter int                     SYNC_STAGES    = 2,
  parameter int                     TIMEOUT_CYCLES = 2**20
) (
  input  logic                   fpga_clk_i,
  input  logic                   fpga_rst_i,
  fabric_config_loader_if.master bus
);
  localparam int MODE_W = $clog2(NUM_SOURCES);
  localparam int WD_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_LOAD, S_DONE, S_ERROR} state_t;

  state_t                 r_state, w_state_nxt;
  logic [MODE_W-1:0]      r_mode_pipe [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] r_rcfg_pipe;
  logic [SYNC_STAGES-1:0] r_warm;
  logic                   r_rcfg_prev;
  logic                   r_startup_pend;
  logic [NUM_SOURCES-1:0] r_src_enable;
  logic [NUM_SOURCES-1:0] r_src_start;
  logic [SLOT_W-1:0]      r_src_slot;
  logic [MODE_W-1:0]      r_active_src;
  logic [WD_W-1:0]        r_wdog;
  logic                   r_seen_busy;
  logic                   r_done;
  logic                   r_error;
  logic [DATA_W-1:0]      r_cfg_dat;
  logic                   r_cfg_vld;

  logic [MODE_W-1:0]      w_mode_sync;
  logic                   w_rcfg_rise;
  logic                   w_mode_ok;
  logic [NUM_SOURCES-1:0] w_mode_oh;
  logic                   w_mode_active;
  logic                   w_act_vld;
  logic                   w_act_busy;
  logic [DATA_W-1:0]      w_act_dat;
  logic                   w_go_start;
  logic                   w_go_load_direct;
  logic                   w_go_done;
  logic                   w_go_error;
  logic                   w_begin;

  // r_warm holds off any decision until the mode synchroniser carries a real sample
  always_ff @(posedge fpga_clk_i or posedge fpga_rst_i) begin
    if (fpga_rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_mode_pipe[i] <= '0;
      r_rcfg_pipe <= '0;
      r_rcfg_prev <= 1'b0;
      r_warm      <= '0;
    end else begin
      r_mode_pipe[0] <= bus.mode_i;
      for (int i = 1; i < SYNC_STAGES; i++) r_mode_pipe[i] <= r_mode_pipe[i-1];
      r_rcfg_pipe <= {r_rcfg_pipe[SYNC_STAGES-2:0], bus.reconfig_i};
      r_rcfg_prev <= r_rcfg_pipe[SYNC_STAGES-1];
      r_warm      <= {r_warm[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign w_mode_sync   = r_mode_pipe[SYNC_STAGES-1];
  assign w_rcfg_rise   = r_warm[SYNC_STAGES-1] & r_rcfg_pipe[SYNC_STAGES-1] & ~r_rcfg_prev;
  assign w_mode_ok     = r_warm[SYNC_STAGES-1] && (32'(w_mode_sync) < NUM_SOURCES);
  assign w_mode_oh     = w_mode_ok ? (NUM_SOURCES'(1) << w_mode_sync) : '0;
  assign w_mode_active = |(w_mode_oh & ACTIVE_MASK);

  always_comb begin
    w_act_vld  = 1'b0;
    w_act_busy = 1'b0;
    w_act_dat  = '0;
    for (int s = 0; s < NUM_SOURCES; s++) begin
      if (MODE_W'(s) == r_active_src) begin
        w_act_vld  = bus.src_valid_i[s];
        w_act_busy = bus.src_busy_i[s];
        w_act_dat  = bus.src_data_i[s*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge fpga_clk_i or posedge fpga_rst_i) begin
    if (fpga_rst_i) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_go_start       = 1'b0;
    w_go_load_direct = 1'b0;
    w_go_done        = 1'b0;
    w_go_error       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((r_startup_pend || w_rcfg_rise) && w_mode_ok) begin
          if (w_mode_active) begin
            w_state_nxt = S_START;
            w_go_start  = 1'b1;
          end else begin
            w_state_nxt      = S_LOAD;
            w_go_load_direct = 1'b1;
          end
        end
      end
      S_START: w_state_nxt = S_LOAD;
      S_LOAD: begin
        // a stalled source wins over a completion seen in the same cycle
        if (r_wdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
          w_state_nxt = S_ERROR;
          w_go_error  = 1'b1;
        end else if (r_seen_busy && !bus.cfg_busy_i && bus.cfg_configured_i && !w_act_busy) begin
          w_state_nxt = S_DONE;
          w_go_done   = 1'b1;
        end
      end
      S_DONE, S_ERROR: begin
        if (w_rcfg_rise && w_mode_ok) begin
          w_state_nxt = S_START;
          w_go_start  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_begin = w_go_start | w_go_load_direct;

  always_ff @(posedge fpga_clk_i or posedge fpga_rst_i) begin
    if (fpga_rst_i) begin
      r_startup_pend <= 1'b1;
      r_src_enable   <= '0;
      r_src_start    <= '0;
      r_src_slot     <= '0;
      r_active_src   <= '0;
      r_wdog         <= '0;
      r_seen_busy    <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_cfg_dat      <= '0;
      r_cfg_vld      <= 1'b0;
    end else begin
      // pad enables stay frozen on the loading source while START/LOAD run
      if (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERROR) r_src_enable <= w_mode_oh;
      r_src_start <= w_go_start ? (w_mode_oh & ACTIVE_MASK) : '0;
      if (w_go_start) r_startup_pend <= 1'b0;
      if (w_begin) begin
        r_active_src <= w_mode_sync;
        r_src_slot   <= bus.slot_i;
        r_done       <= 1'b0;
        r_error      <= 1'b0;
      end
      if (w_go_done)  r_done  <= 1'b1;
      if (w_go_error) r_error <= 1'b1;
      if (w_begin || r_state == S_START) begin
        r_wdog      <= '0;
        r_seen_busy <= 1'b0;
      end else if (r_state == S_LOAD) begin
        r_wdog <= w_act_vld ? '0 : r_wdog + WD_W'(1);
        if (bus.cfg_busy_i) r_seen_busy <= 1'b1;
      end
      r_cfg_vld <= (r_state == S_LOAD) && w_act_vld;
      if ((r_state == S_LOAD) && w_act_vld) r_cfg_dat <= w_act_dat;
    end
  end

`ifdef FABRIC_CONFIG_WORD_COUNT_EN
  logic [31:0] r_word_cnt;
  always_ff @(posedge fpga_clk_i or posedge fpga_rst_i) begin
    if (fpga_rst_i)                           r_word_cnt <= '0;
    else if (w_begin)                         r_word_cnt <= '0;
    else if (r_cfg_vld && (r_word_cnt != '1)) r_word_cnt <= r_word_cnt + 32'd1;
  end
  assign bus.word_count_o = r_word_cnt;
`else
  assign bus.word_count_o = 32'd0;
`endif

  assign bus.src_enable_o = r_src_enable;
  assign bus.src_start_o  = r_src_start;
  assign bus.src_slot_o   = r_src_slot;
  assign bus.cfg_data_o   = r_cfg_dat;
  assign bus.cfg_valid_o  = r_cfg_vld;
  assign bus.active_src_o = r_active_src;
  assign bus.busy_o       = (r_state == S_START) || (r_state == S_LOAD);
  assign bus.done_o       = r_done;
  assign bus.error_o      = r_error;
endmodule

// File: tb/tb_fabric_config_loader.sv
// Scoreboarded bench for fabric_config_loader: expected cfg words and start pulses are queued by the
// stimulus and popped by a negedge monitor; a second instance covers an out-of-range mode with three sources.
module tb_fabric_config_loader;
  localparam int DW = 32;
  localparam int SW = 4;
`ifdef FABRIC_CONFIG_WORD_COUNT_EN
  localparam logic [31:0] WC4 = 32'd4;
`else
  localparam logic [31:0] WC4 = 32'd0;
`endif

  typedef struct {logic [31:0] dat; int cyc;} word_exp_t;
  typedef struct {logic [1:0] vec; logic [3:0] slot; int cyc;} start_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  word_exp_t  exp_words[$];
  start_exp_t exp_starts[$];
  logic [2:0] d3_start_or = '0;
  logic [31:0] words1 [4] = '{32'hDEAD_BEEF, 32'h0000_0001, 32'hFFFF_FFFF, 32'h1234_ABCD};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fabric_config_loader_if #(.NUM_SOURCES(2), .DATA_W(DW), .SLOT_W(SW)) bus ();
  fabric_config_loader_if #(.NUM_SOURCES(3), .DATA_W(DW), .SLOT_W(SW)) bus3 ();

  fabric_config_loader #(.NUM_SOURCES(2), .ACTIVE_MASK(2'b01), .DATA_W(DW), .SLOT_W(SW),
                         .SYNC_STAGES(2), .TIMEOUT_CYCLES(64))
    dut (.fpga_clk_i(clk), .fpga_rst_i(rst), .bus(bus.master));

  fabric_config_loader #(.NUM_SOURCES(3), .ACTIVE_MASK(3'b001), .DATA_W(DW), .SLOT_W(SW),
                         .SYNC_STAGES(2), .TIMEOUT_CYCLES(64))
    dut3 (.fpga_clk_i(clk), .fpga_rst_i(rst), .bus(bus3.master));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_word(input logic [31:0] d);
    word_exp_t e;
    e.dat = d;
    e.cyc = cyc + 1;
    exp_words.push_back(e);
  endtask

  task automatic push_start(input logic [1:0] v, input logic [3:0] s, input int at);
    start_exp_t e;
    e.vec = v;
    e.slot = s;
    e.cyc = at;
    exp_starts.push_back(e);
  endtask

  // fabric_config handshake: busy high for two cycles, then low with configured set
  task automatic finish_load();
    bus.cfg_busy_i = 1'b1;
    tick(2);
    bus.cfg_busy_i = 1'b0;
    bus.cfg_configured_i = 1'b1;
    tick(2);
  endtask

  always @(negedge clk) begin
    word_exp_t  w;
    start_exp_t s;
    d3_start_or <= d3_start_or | bus3.src_start_o;
    if (bus.cfg_valid_o) begin
      if (exp_words.size() == 0) check("cfg_word_unexpected", bus.cfg_valid_o, 1'b0);
      else begin
        w = exp_words.pop_front();
        check("cfg_word_data", bus.cfg_data_o, w.dat);
        check("cfg_word_cycle", cyc, w.cyc);
      end
    end
    if (bus.src_start_o != 2'b00) begin
      if (exp_starts.size() == 0) check("start_unexpected", bus.src_start_o, 2'b00);
      else begin
        s = exp_starts.pop_front();
        check("start_vec", bus.src_start_o, s.vec);
        check("start_slot", bus.src_slot_o, s.slot);
        check("start_cycle", cyc, s.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    bus.mode_i = 1'b0;  bus.slot_i = 4'd3;  bus.reconfig_i = 1'b0;
    bus.src_busy_i = '0; bus.src_data_i = '0; bus.src_valid_i = '0;
    bus.cfg_busy_i = 1'b0; bus.cfg_configured_i = 1'b0;
    bus3.mode_i = 2'd3; bus3.slot_i = 4'd1; bus3.reconfig_i = 1'b0;
    bus3.src_busy_i = '0; bus3.src_data_i = '0; bus3.src_valid_i = '0;
    bus3.cfg_busy_i = 1'b0; bus3.cfg_configured_i = 1'b1;

    // reset state
    tick(3);
    check("rst_enable", bus.src_enable_o, 2'b00);
    check("rst_start", bus.src_start_o, 2'b00);
    check("rst_cfg_valid", bus.cfg_valid_o, 1'b0);
    check("rst_busy_done_err", {bus.busy_o, bus.done_o, bus.error_o}, 3'b000);
    check("rst_word_count", bus.word_count_o, 32'd0);

    // startup load from active source 0, slot 3; source 1 chatter must be ignored
    rst = 1'b0;
    push_start(2'b01, 4'd3, cyc + 3);
    tick(4);
    check("t1_busy", bus.busy_o, 1'b1);
    check("t1_enable", bus.src_enable_o, 2'b01);
    check("t1_active_src", bus.active_src_o, 1'b0);
    check("t1_slot", bus.src_slot_o, 4'd3);
    for (int k = 0; k < 4; k++) begin
      bus.src_data_i = {32'hBAD0_0000 + 32'(k), words1[k]};
      bus.src_valid_i = 2'b11;
      push_word(words1[k]);
      tick(1);
    end
    bus.src_valid_i = 2'b00;
    tick(2);
    finish_load();
    check("t1_done", bus.done_o, 1'b1);
    check("t1_busy_after", bus.busy_o, 1'b0);
    check("t1_error", bus.error_o, 1'b0);
    check("t1_word_count", bus.word_count_o, WC4);

    // reconfig, then mode flips to 1 mid-load: enables and active source stay frozen
    bus.slot_i = 4'd5;
    bus.reconfig_i = 1'b1;
    push_start(2'b01, 4'd5, cyc + 3);
    tick(4);
    bus.reconfig_i = 1'b0;
    bus.mode_i = 1'b1;
    tick(5);
    check("t3_active_frozen", bus.active_src_o, 1'b0);
    check("t3_enable_frozen", bus.src_enable_o, 2'b01);
    check("t3_busy", bus.busy_o, 1'b1);
    bus.src_data_i = {32'h0BAD_0BAD, 32'h1234_5678};
    bus.src_valid_i = 2'b11;
    push_word(32'h1234_5678);
    tick(1);
    bus.src_valid_i = 2'b00;
    finish_load();
    check("t3_done", bus.done_o, 1'b1);
    check("t3_enable_new", bus.src_enable_o, 2'b10);
    check("t3_active_last", bus.active_src_o, 1'b0);

    // watchdog: 64 LOAD cycles without a word
    bus.mode_i = 1'b0;
    tick(3);
    bus.reconfig_i = 1'b1;
    push_start(2'b01, 4'd5, cyc + 3);
    tick(4);
    bus.reconfig_i = 1'b0;
    tick(63);
    check("t4_error_early", bus.error_o, 1'b0);
    check("t4_busy_early", bus.busy_o, 1'b1);
    tick(1);
    check("t4_error", bus.error_o, 1'b1);
    check("t4_busy", bus.busy_o, 1'b0);
    check("t4_done", bus.done_o, 1'b0);
    bus.reconfig_i = 1'b1;
    push_start(2'b01, 4'd5, cyc + 3);
    tick(3);
    check("t4_restart_error_clr", bus.error_o, 1'b0);
    check("t4_restart_busy", bus.busy_o, 1'b1);
    tick(1);
    bus.reconfig_i = 1'b0;

    // reset while a word is on cfg
    bus.src_data_i = {32'h0, 32'hCAFE_F00D};
    bus.src_valid_i = 2'b01;
    push_word(32'hCAFE_F00D);
    tick(1);
    bus.src_valid_i = 2'b00;
    check("t5_valid_pre_rst", bus.cfg_valid_o, 1'b1);
    #5;
    rst = 1'b1;
    #1;
    check("t5_rst_valid", bus.cfg_valid_o, 1'b0);
    check("t5_rst_data", bus.cfg_data_o, 32'd0);
    check("t5_rst_enable", bus.src_enable_o, 2'b00);
    check("t5_rst_flags", {bus.busy_o, bus.done_o, bus.error_o}, 3'b000);
    check("t5_rst_slot", bus.src_slot_o, 4'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_start(2'b01, 4'd5, cyc + 3);
    tick(4);
    check("t5_reload_busy", bus.busy_o, 1'b1);
    finish_load();
    check("t5_reload_done", bus.done_o, 1'b1);

    // passive source 1 selected at reset: no start, direct load, source 0 ignored
    rst = 1'b1;
    bus.mode_i = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(3);
    check("t2_enable", bus.src_enable_o, 2'b10);
    check("t2_busy", bus.busy_o, 1'b1);
    check("t2_active_src", bus.active_src_o, 1'b1);
    for (int k = 0; k < 3; k++) begin
      bus.src_data_i = {words1[k], 32'h5555_0000 + 32'(k)};
      bus.src_valid_i = 2'b11;
      push_word(words1[k]);
      tick(1);
    end
    bus.src_valid_i = 2'b00;
    tick(2);
    finish_load();
    check("t2_done", bus.done_o, 1'b1);
    check("t2_start_none", bus.src_start_o, 2'b00);

    // three sources, mode 3 out of range
    check("t6_enable", bus3.src_enable_o, 3'b000);
    check("t6_flags", {bus3.busy_o, bus3.done_o, bus3.error_o}, 3'b000);
    check("t6_start_seen", d3_start_or, 3'b000);

    tick(2);
    check("words_pending", exp_words.size(), 0);
    check("starts_pending", exp_starts.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
